// File: rtl/fp_multifunc_req_ctrl_if.sv
// fp_multifunc_req_ctrl_if: bundles the request channel, the response channel, and the
// operand/result wires of the FP multifunction unit used by fp_multifunc_req_ctrl.
//   W        : FP word width (sig_width + exp_width + 1)
//   slave    : controller view (takes requests, drives the unit, returns responses)
//   master   : environment view (scheduler front end plus the multifunction unit)
interface fp_multifunc_req_ctrl_if #(
  parameter int unsigned W = 32
);
  // Request channel
  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] req_a;
  logic [15:0]  req_func;
  logic [2:0]   req_rnd;
  // Response channel
  logic         resp_valid;
  logic         resp_ready;
  logic [W-1:0] resp_z;
  logic [7:0]   resp_status;
  // Multifunction unit side
  logic [W-1:0] mf_a;
  logic [15:0]  mf_func;
  logic [2:0]   mf_rnd;
  logic         mf_DG_ctrl;
  logic [W-1:0] mf_z;
  logic [7:0]   mf_status;

  modport slave (
    input  req_valid, req_a, req_func, req_rnd, resp_ready, mf_z, mf_status,
    output req_ready, resp_valid, resp_z, resp_status, mf_a, mf_func, mf_rnd, mf_DG_ctrl
  );

  modport master (
    output req_valid, req_a, req_func, req_rnd, resp_ready, mf_z, mf_status,
    input  req_ready, resp_valid, resp_z, resp_status, mf_a, mf_func, mf_rnd, mf_DG_ctrl
  );
endinterface

// File: rtl/fp_multifunc_req_ctrl.sv
// fp_multifunc_req_ctrl: one-at-a-time request/response sequencer in front of the
// datapath-gated FP multifunction unit. An accepted request is registered onto the unit
// inputs, DG_ctrl is held high for LAT cycles, and the unit's z/status are captured and
// returned over the response channel.
//
// Ports:
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : fp_multifunc_req_ctrl_if.slave (request, response and unit-side signals)
//
// Optional feature macro FP_MF_REQ_FUNC_CHECK_EN: when defined, a request whose func is not
// one-hot or falls outside func_select is answered immediately with z=0, status=8'h04,
// without touching the unit. When undefined every accepted request is issued unchanged.
module fp_multifunc_req_ctrl #(
  parameter int unsigned sig_width   = 23,
  parameter int unsigned exp_width   = 8,
  parameter int unsigned func_select = 127,
  parameter int unsigned LAT         = 2
) (
  input logic                  clk,
  input logic                  rst_n,
  fp_multifunc_req_ctrl_if.slave bus
);

  localparam int unsigned W = sig_width + exp_width + 1;

  if (LAT < 1 || LAT > 15) begin : g_lat_chk
    $error("LAT must be in 1..15");
  end
  if (func_select > 32'h0000_FFFF) begin : g_fsel_chk
    $error("func_select must fit in 16 bits");
  end

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e       state_q;
  logic [3:0]   cnt_q;
  logic         req_ready_q;
  logic         resp_valid_q;
  logic         dg_q;
  logic [W-1:0] mf_a_q;
  logic [15:0]  mf_func_q;
  logic [2:0]   mf_rnd_q;
  logic [W-1:0] resp_z_q;
  logic [7:0]   resp_status_q;

`ifdef FP_MF_REQ_FUNC_CHECK_EN
  localparam logic [15:0] FuncMask = 16'(func_select);
  logic func_ok;
  assign func_ok = $onehot(bus.req_func) && ((bus.req_func & ~FuncMask) == 16'h0000);
`endif

  // Ready is kept as a register so it is low during reset and never follows an input
  // combinationally; it is set whenever the FSM settles into (or stays in) idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      cnt_q         <= 4'd0;
      req_ready_q   <= 1'b0;
      resp_valid_q  <= 1'b0;
      dg_q          <= 1'b0;
      mf_a_q        <= '0;
      mf_func_q     <= 16'h0000;
      mf_rnd_q      <= 3'd0;
      resp_z_q      <= '0;
      resp_status_q <= 8'h00;
    end else begin
      unique case (state_q)
        StIdle: begin
          req_ready_q <= 1'b1;
          if (bus.req_valid && req_ready_q) begin
            req_ready_q <= 1'b0;
`ifdef FP_MF_REQ_FUNC_CHECK_EN
            if (func_ok) begin
              mf_a_q    <= bus.req_a;
              mf_func_q <= bus.req_func;
              mf_rnd_q  <= bus.req_rnd;
              dg_q      <= 1'b1;
              cnt_q     <= 4'(LAT - 1);
              state_q   <= StBusy;
            end else begin
              // Rejected op: unit stays gated and untouched, answer with invalid flag.
              resp_z_q      <= '0;
              resp_status_q <= 8'h04;
              resp_valid_q  <= 1'b1;
              state_q       <= StResp;
            end
`else
            mf_a_q    <= bus.req_a;
            mf_func_q <= bus.req_func;
            mf_rnd_q  <= bus.req_rnd;
            dg_q      <= 1'b1;
            cnt_q     <= 4'(LAT - 1);
            state_q   <= StBusy;
`endif
          end
        end
        StBusy: begin
          if (cnt_q == 4'd0) begin
            resp_z_q      <= bus.mf_z;
            resp_status_q <= bus.mf_status;
            dg_q          <= 1'b0;
            resp_valid_q  <= 1'b1;
            state_q       <= StResp;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StResp: begin
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            state_q      <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_z      = resp_z_q;
  assign bus.resp_status = resp_status_q;
  assign bus.mf_a        = mf_a_q;
  assign bus.mf_func     = mf_func_q;
  assign bus.mf_rnd      = mf_rnd_q;
  assign bus.mf_DG_ctrl  = dg_q;

endmodule

// File: tb/tb_fp_multifunc_req_ctrl.sv
// Testbench for fp_multifunc_req_ctrl. The bench plays both the scheduler and the
// multifunction unit. The unit model returns a value stamped with the edge count, so the
// expected response of a request accepted at edge E0 is a function of its operands and of
// E0+LAT-1 (the cycle whose unit output is sampled at edge E0+LAT). Accepted requests push
// expected responses into a queue; a monitor pops and compares on every response handshake.
module tb_fp_multifunc_req_ctrl;

  localparam int unsigned SW   = 23;
  localparam int unsigned EW   = 8;
  localparam int unsigned W    = SW + EW + 1;
  localparam int unsigned LAT  = 2;
  localparam int unsigned FSEL = 127;
  localparam logic [31:0] K    = 32'h9E3779B9;

  typedef struct packed {
    logic [W-1:0] z;
    logic [7:0]   st;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  int   ecnt  = 0;
  int   n_acc = 0;
  int   rdy_mode = 0;
  int   acc_e[$];
  exp_t q[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  fp_multifunc_req_ctrl_if #(.W(W)) bus ();

  fp_multifunc_req_ctrl #(
    .sig_width  (SW),
    .exp_width  (EW),
    .func_select(FSEL),
    .LAT        (LAT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always @(posedge clk) ecnt <= ecnt + 1;

  // Unit model: garbage while gated, operand/cycle-stamped result while enabled.
  assign bus.mf_z      = bus.mf_DG_ctrl ? (bus.mf_a ^ (32'(ecnt) * K)) : 32'hDEADBEEF;
  assign bus.mf_status = bus.mf_DG_ctrl ?
      ({bus.mf_rnd, 5'b0} ^ bus.mf_func[15:8] ^ bus.mf_func[7:0] ^ 8'(ecnt)) : 8'hEE;

  function automatic exp_t ref_resp(input logic [W-1:0] a, input logic [15:0] f,
                                    input logic [2:0] r, input int e0);
    exp_t e;
    int   t;
    t    = e0 + int'(LAT) - 1;
    e.z  = a ^ (32'(t) * K);
    e.st = {r, 5'b0} ^ f[15:8] ^ f[7:0] ^ 8'(t);
`ifdef FP_MF_REQ_FUNC_CHECK_EN
    if (!$onehot(f) || ((f & ~16'(FSEL)) != 16'h0000)) begin
      e.z  = '0;
      e.st = 8'h04;
    end
`endif
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Acceptor: a handshake seen mid-cycle completes at the next edge (ecnt+1).
  always @(negedge clk) begin
    #1;
    if (!rst_n) begin
      q.delete();
    end else if (bus.req_valid && bus.req_ready) begin
      q.push_back(ref_resp(bus.req_a, bus.req_func, bus.req_rnd, ecnt + 1));
      acc_e.push_back(ecnt + 1);
      n_acc++;
    end
  end

  always @(negedge clk) begin
    case (rdy_mode)
      0:       bus.resp_ready = 1'b0;
      1:       bus.resp_ready = 1'b1;
      default: bus.resp_ready = ($urandom_range(0, 2) != 0);
    endcase
  end

  // Monitor
  logic         hold = 1'b0;
  logic [W-1:0] hz;
  logic [7:0]   hs;
  int           run = 0;

  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      run  = 0;
      hold = 1'b0;
    end else begin
      if (bus.mf_DG_ctrl) begin
        run++;
        check("ready_while_busy", 64'(bus.req_ready), 64'd0);
      end else if (run > 0) begin
        check("dg_pulse_len", 64'(run), 64'(LAT));
        run = 0;
      end
      if (bus.resp_valid) begin
        check("resp_exclusive", 64'({bus.req_ready, bus.mf_DG_ctrl}), 64'd0);
        if (hold) begin
          check("resp_z_stable", 64'(bus.resp_z), 64'(hz));
          check("resp_status_stable", 64'(bus.resp_status), 64'(hs));
        end
        if (bus.resp_ready) begin
          if (q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_resp: got z=%h with nothing outstanding, expected none",
                     bus.resp_z);
          end else begin
            mon_e = q.pop_front();
            check("resp_z", 64'(bus.resp_z), 64'(mon_e.z));
            check("resp_status", 64'(bus.resp_status), 64'(mon_e.st));
          end
          hold = 1'b0;
        end else begin
          hold = 1'b1;
          hz   = bus.resp_z;
          hs   = bus.resp_status;
        end
      end else begin
        hold = 1'b0;
      end
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [15:0] f, input logic [2:0] r);
    int c;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_a     = a;
    bus.req_func  = f;
    bus.req_rnd   = r;
    c = n_acc;
    for (int k = 0; k < 50; k++) begin
      #3;
      if (n_acc != c) break;
      @(negedge clk);
    end
    if (n_acc == c) begin
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout: got no accept in 50 cycles, expected one");
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 100; k++) begin
      if (q.size() == 0) break;
      @(negedge clk);
    end
    if (q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: got %0d responses pending, expected 0", q.size());
    end
  endtask

  function automatic logic [15:0] pick_func();
    logic [15:0] one;
    one = 16'h0001;
    case ($urandom_range(0, 3))
      0:       return 16'h0003;
      1:       return one << $urandom_range(0, 15);
      default: return one << $urandom_range(0, 6);
    endcase
  endfunction

  initial begin
    int acc0;
    bus.req_valid = 1'b0;
    bus.req_a     = '0;
    bus.req_func  = 16'h0000;
    bus.req_rnd   = 3'd0;

    repeat (3) @(negedge clk);
    #3;
    check("reset_ctrl", 64'({bus.req_ready, bus.resp_valid, bus.mf_DG_ctrl, bus.mf_a,
                             bus.mf_func, bus.mf_rnd}), 64'd0);
    check("reset_resp", 64'({bus.resp_z, bus.resp_status}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed op, then held response with a competing request that must be ignored.
    rdy_mode = 0;
    acc0 = n_acc;
    send(32'h3F800000, 16'h0001, 3'd0);
    @(negedge clk);
    bus.req_a = 32'h12345678;
    repeat (LAT + 5) @(negedge clk);
    check("no_accept_while_held", 64'(n_acc), 64'(acc0 + 1));
    bus.req_valid = 1'b0;
    rdy_mode = 1;
    drain();

    // Reset while BUSY: everything clears and the result is never presented.
    send(32'(($urandom())), 16'h0004, 3'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    #3;
    check("midbusy_reset_ctrl", 64'({bus.req_ready, bus.resp_valid, bus.mf_DG_ctrl, bus.mf_a,
                                     bus.mf_func, bus.mf_rnd}), 64'd0);
    check("midbusy_reset_resp", 64'({bus.resp_z, bus.resp_status}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);

    // Back-to-back with resp_ready high: one accept every LAT+2 cycles.
    acc_e.delete();
    for (int i = 0; i < 4; i++) begin
      logic [15:0] one;
      one = 16'h0001;
      send(32'($urandom()), one << $urandom_range(0, 6), 3'($urandom_range(0, 7)));
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    for (int i = 1; i < 4; i++) begin
      check("accept_spacing", 64'(acc_e[i] - acc_e[i-1]), 64'(LAT + 2));
    end
    drain();

    // Non-one-hot func.
    send(32'($urandom()), 16'h0003, 3'd2);
    @(negedge clk);
    bus.req_valid = 1'b0;
    drain();

    // Random traffic with random response back-pressure.
    rdy_mode = 2;
    repeat (40) begin
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        bus.req_valid = 1'b0;
      end
      send(32'($urandom()), pick_func(), 3'($urandom_range(0, 7)));
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    rdy_mode = 1;
    drain();
    repeat (4) @(negedge clk);
    check("queue_empty", 64'(q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
